// File: rtl/booth_csa_accum_if.sv
// ----------------------------------------------------------------------------
// booth_csa_accum_if
//   Operand/result handshake bundle for booth_csa_accum.
//   Parameter W : operand width (product vectors are 2*W bits).
//   Signals:
//     in_valid  upstream -> block   operand pair valid
//     in_ready  block -> upstream   block can accept operands
//     a, b      upstream -> block   multiplicand / multiplier (W bits)
//     out_valid block -> downstream sum_vec/carry_vec hold a finished product
//     out_ready downstream -> block vectors consumed
//     sum_vec   block -> downstream carry-save sum vector (2W bits)
//     carry_vec block -> downstream carry-save carry vector, weight-aligned
//     busy      block -> system     high while a product is in flight or held
//   Modports: master (operand source / result sink), slave (the multiplier).
// ----------------------------------------------------------------------------
interface booth_csa_accum_if #(
   parameter int W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      a;
   logic [W-1:0]      b;
   logic              out_valid;
   logic              out_ready;
   logic [2*W-1:0]    sum_vec;
   logic [2*W-1:0]    carry_vec;
   logic              busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sum_vec, carry_vec, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sum_vec, carry_vec, busy
   );
endinterface

// File: rtl/booth_csa_accum.sv
// ----------------------------------------------------------------------------
// booth_csa_accum
//   Iterative radix-4 Booth multiplier front end. One Booth digit per cycle is
//   folded into a carry-save (sum, carry) register pair through a single 3:2
//   compressor row. The finished pair is offered on a valid/ready handshake;
//   downstream forms a*b as (sum_vec + carry_vec) mod 2^(2W).
//
//   Parameter W : operand width, even and >= 4 (must match the interface W).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    booth_csa_accum_if.slave: in_valid/in_ready/a/b,
//            out_valid/out_ready/sum_vec/carry_vec, busy
//
//   Build option BOOTH_UNSIGNED_EN: when defined, a and b are unsigned; the
//   multiplier is zero-extended by two bits and W/2+1 digits are retired.
//   Otherwise operands are two's complement and W/2 digits are retired.
// ----------------------------------------------------------------------------
module booth_csa_accum #(
   parameter int W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   booth_csa_accum_if.slave   bus
);

   localparam int unsigned PW = 2 * W;
`ifdef BOOTH_UNSIGNED_EN
   localparam int unsigned N  = W / 2 + 1;
`else
   localparam int unsigned N  = W / 2;
`endif
   // multiplier register holds {ext, b, 1'b0}: 2N+1 bits covers every triplet
   localparam int unsigned MW = 2 * N + 1;
   localparam int unsigned CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [W-1:0]     areg;
   logic [MW-1:0]    mreg;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    sum_q;
   logic [PW-1:0]    carry_q;

   logic             accept;
   logic [2:0]       trip;
   logic             sel_one;
   logic             sel_two;
   logic             neg;
   logic [PW-1:0]    aext;
   logic [PW-1:0]    mag;
   logic [PW-1:0]    shifted;
   logic [PW-1:0]    pp;
   logic [PW-1:0]    csa_sum;
   logic [PW-1:0]    csa_maj;
   logic [PW-1:0]    csa_carry;

   assign accept = (state == IDLE) && bus.in_valid;

   // -------------------------------------------------------------------------
   // control FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.in_valid)    state_nx = RUN;
         RUN:  if (cnt == LAST)     state_nx = DONE;
         DONE: if (bus.out_ready)   state_nx = IDLE;
         default:                   state_nx = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Booth digit selection: triplet {b[2i+1], b[2i], b[2i-1]} sits at
   // mreg[2i+2:2i] because of the appended zero below b[0].
   // -------------------------------------------------------------------------
   always_comb begin
      trip = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (cnt == CW'(i)) trip = mreg[2*i +: 3];
      end
   end

   always_comb begin
      sel_one = 1'b0;
      sel_two = 1'b0;
      neg     = 1'b0;
      unique case (trip)
         3'b001, 3'b010: sel_one = 1'b1;
         3'b011:         sel_two = 1'b1;
         3'b100: begin   sel_two = 1'b1; neg = 1'b1; end
         3'b101, 3'b110: begin sel_one = 1'b1; neg = 1'b1; end
         default: ;      // 000 / 111: zero digit
      endcase
   end

`ifdef BOOTH_UNSIGNED_EN
   assign aext = {{W{1'b0}}, areg};
`else
   assign aext = {{W{areg[W-1]}}, areg};
`endif

   assign mag     = sel_two ? (aext << 1) : (sel_one ? aext : '0);
   assign shifted = mag << {cnt, 1'b0};

   // Negative digits invert the already-shifted row, so the two's-complement
   // hot one lands at bit 0, which the left-shifted carry vector always leaves
   // free. That lets the +1 ride in the same compressor row.
   assign pp = neg ? ~shifted : shifted;

   assign csa_sum   = sum_q ^ carry_q ^ pp;
   assign csa_maj   = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
   assign csa_carry = {csa_maj[PW-2:0], neg};

   // -------------------------------------------------------------------------
   // datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         areg    <= '0;
         mreg    <= '0;
         cnt     <= '0;
         sum_q   <= '0;
         carry_q <= '0;
      end else if (accept) begin
         areg    <= bus.a;
`ifdef BOOTH_UNSIGNED_EN
         mreg    <= {2'b00, bus.b, 1'b0};
`else
         mreg    <= {bus.b, 1'b0};
`endif
         cnt     <= '0;
         sum_q   <= '0;
         carry_q <= '0;
      end else if (state == RUN) begin
         sum_q   <= csa_sum;
         carry_q <= csa_carry;
         if (cnt != LAST) cnt <= cnt + 1'b1;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == RUN) || (state == DONE);
   assign bus.sum_vec   = sum_q;
   assign bus.carry_vec = carry_q;

endmodule
